// File: rtl/md4_block_pipe_pkg.sv
// Shared MD4 definitions: round constants, rotation and word-order tables,
// boolean functions, byte swapping and the engine state encoding.
package md4_block_pipe_pkg;

    localparam logic [31:0] K_G = 32'h5A827999;
    localparam logic [31:0] K_H = 32'h6ED9EBA1;

    localparam logic [4:0] ROT_F [4] = '{5'd3, 5'd7, 5'd11, 5'd19};
    localparam logic [4:0] ROT_G [4] = '{5'd3, 5'd5, 5'd9,  5'd13};
    localparam logic [4:0] ROT_H [4] = '{5'd3, 5'd9, 5'd11, 5'd15};

    localparam logic [3:0] IDX_F [16] = '{4'd0, 4'd1, 4'd2,  4'd3,  4'd4, 4'd5, 4'd6,  4'd7,
                                          4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
    localparam logic [3:0] IDX_G [16] = '{4'd0, 4'd4, 4'd8, 4'd12, 4'd1, 4'd5, 4'd9, 4'd13,
                                          4'd2, 4'd6, 4'd10, 4'd14, 4'd3, 4'd7, 4'd11, 4'd15};
    localparam logic [3:0] IDX_H [16] = '{4'd0, 4'd8, 4'd4, 4'd12, 4'd2, 4'd10, 4'd6, 4'd14,
                                          4'd1, 4'd9, 4'd5, 4'd13, 4'd3, 4'd11, 4'd7, 4'd15};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic logic [31:0] md4_f(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) | (~x & z);
    endfunction

    function automatic logic [31:0] md4_g(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    function automatic logic [31:0] md4_h(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return x ^ y ^ z;
    endfunction

    function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] sh);
        logic [63:0] t;
        t = {x, x} << sh;
        return t[63:32];
    endfunction

    function automatic logic [31:0] byteswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [511:0] swap_block(input logic [511:0] blk);
        logic [511:0] r;
        r = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            r[32*i +: 32] = byteswap32(blk[32*i +: 32]);
        end
        return r;
    endfunction

endpackage

// File: rtl/md4_block_pipe_step.sv
// One combinational MD4 step; the updated word is returned in the b slot so the
// (a,b,c,d) tuple rotates and every step always updates its own a input.
module md4_step
    import md4_block_pipe_pkg::*;
(
    input  logic [31:0]  a,
    input  logic [31:0]  b,
    input  logic [31:0]  c,
    input  logic [31:0]  d,
    input  logic [511:0] msg,
    input  logic [5:0]   step,
    output logic [31:0]  a_out,
    output logic [31:0]  b_out,
    output logic [31:0]  c_out,
    output logic [31:0]  d_out
);

    logic [31:0] words [16];
    logic [31:0] fv;
    logic [31:0] k;
    logic [4:0]  sh;
    logic [3:0]  wi;
    logic [31:0] t;

    always_comb begin
        for (int unsigned i = 0; i < 16; i++) begin
            words[i] = msg[511 - 32*i -: 32];
        end
    end

    always_comb begin
        fv = '0;
        k  = '0;
        sh = '0;
        wi = '0;
        case (step[5:4])
            2'd0: begin
                fv = md4_f(b, c, d);
                k  = '0;
                sh = ROT_F[step[1:0]];
                wi = IDX_F[step[3:0]];
            end
            2'd1: begin
                fv = md4_g(b, c, d);
                k  = K_G;
                sh = ROT_G[step[1:0]];
                wi = IDX_G[step[3:0]];
            end
            default: begin
                fv = md4_h(b, c, d);
                k  = K_H;
                sh = ROT_H[step[1:0]];
                wi = IDX_H[step[3:0]];
            end
        endcase
        t = rotl32(a + fv + words[wi] + k, sh);
    end

    assign a_out = d;
    assign b_out = t;
    assign c_out = b;
    assign d_out = c;

endmodule

// File: rtl/md4_block_pipe.sv
// MD4 compression engine with configurable steps per clock and valid/ready
// handshaking on both sides.
module md4_block_pipe
    import md4_block_pipe_pkg::*;
#(
    parameter int unsigned STEPS_PER_CYCLE = 1,
    parameter int unsigned BYTESWAP        = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  state_a,
    input  logic [31:0]  state_b,
    input  logic [31:0]  state_c,
    input  logic [31:0]  state_d,
    input  logic [511:0] data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  newstate_a,
    output logic [31:0]  newstate_b,
    output logic [31:0]  newstate_c,
    output logic [31:0]  newstate_d,
    output logic         busy
);

    localparam int unsigned NCYC    = 48 / STEPS_PER_CYCLE;
    localparam logic [5:0]  FIN_CNT = 6'(NCYC);

    if (STEPS_PER_CYCLE < 1 || STEPS_PER_CYCLE > 16 || (48 % STEPS_PER_CYCLE) != 0) begin : g_bad_steps
        $error("md4_block_pipe: STEPS_PER_CYCLE must be one of 1,2,3,4,6,8,12,16");
    end

    state_t       state;
    logic [5:0]   cnt;
    logic [31:0]  orig_a, orig_b, orig_c, orig_d;
    logic [31:0]  aa, bb, cc, dd;
    logic [511:0] msg;
    logic [511:0] msg_in;
    logic [5:0]   step_base;
    logic         accept;
    logic         run_step;

    logic [31:0] ch_a [STEPS_PER_CYCLE+1];
    logic [31:0] ch_b [STEPS_PER_CYCLE+1];
    logic [31:0] ch_c [STEPS_PER_CYCLE+1];
    logic [31:0] ch_d [STEPS_PER_CYCLE+1];

    assign msg_in    = (BYTESWAP != 0) ? swap_block(data) : data;
    assign step_base = 6'(cnt * STEPS_PER_CYCLE);
    assign accept    = in_valid && in_ready;
    // One extra RUN cycle (cnt == FIN_CNT) folds the feed-forward add.
    assign run_step  = (state == RUN) && (cnt != FIN_CNT);

    always_comb begin
        in_ready = 1'b0;
        case (state)
            IDLE:    in_ready = 1'b1;
            DONE:    in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    assign ch_a[0] = aa;
    assign ch_b[0] = bb;
    assign ch_c[0] = cc;
    assign ch_d[0] = dd;

    for (genvar k = 0; k < STEPS_PER_CYCLE; k++) begin : g_chain
        md4_step u_step (
            .a     (ch_a[k]),
            .b     (ch_b[k]),
            .c     (ch_c[k]),
            .d     (ch_d[k]),
            .msg   (msg),
            .step  (step_base + 6'(k)),
            .a_out (ch_a[k+1]),
            .b_out (ch_b[k+1]),
            .c_out (ch_c[k+1]),
            .d_out (ch_d[k+1])
        );
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            orig_a <= state_a;
            orig_b <= state_b;
            orig_c <= state_c;
            orig_d <= state_d;
            msg    <= msg_in;
            aa     <= state_a;
            bb     <= state_b;
            cc     <= state_c;
            dd     <= state_d;
        end else if (run_step) begin
            aa <= ch_a[STEPS_PER_CYCLE];
            bb <= ch_b[STEPS_PER_CYCLE];
            cc <= ch_c[STEPS_PER_CYCLE];
            dd <= ch_d[STEPS_PER_CYCLE];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            newstate_a <= '0;
            newstate_b <= '0;
            newstate_c <= '0;
            newstate_d <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state <= RUN;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (cnt == FIN_CNT) begin
                        newstate_a <= orig_a + aa;
                        newstate_b <= orig_b + bb;
                        newstate_c <= orig_c + cc;
                        newstate_d <= orig_d + dd;
                        out_valid  <= 1'b1;
                        busy       <= 1'b0;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            state <= RUN;
                            cnt   <= '0;
                            busy  <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md4_block_pipe.sv
// Directed bench for md4_block_pipe: known digests, handshake corner cases,
// mid-run reset, and a parameter sweep against a behavioural MD4 model.
module tb_md4_block_pipe;

    localparam logic [127:0] IV        = {32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] BLK_ABC   = {32'h61626380, 416'h0, 32'h18000000, 32'h0};
    localparam logic [127:0] EXP_EMPTY = {32'he0cfd631, 32'h31e96ad1, 32'hd7593cb7, 32'hc089c0e0};
    localparam logic [127:0] EXP_ABC   = {32'h7a0148a4, 32'h52d821af, 32'he80ac15f, 32'h9d72a67a};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [31:0]  st_a, st_b, st_c, st_d;
    logic [511:0] data;

    logic        m_in_valid, m_in_ready, m_out_valid, m_out_ready, m_busy;
    logic [31:0] m_na, m_nb, m_nc, m_nd;

    logic        s_in_valid, s_out_ready;
    logic        sw_in_ready [16];
    logic        sw_valid    [16];
    logic        sw_busy     [16];
    logic [31:0] sw_a [16];
    logic [31:0] sw_b [16];
    logic [31:0] sw_c [16];
    logic [31:0] sw_d [16];

    int n_tests = 0;
    int n_fail  = 0;

    function automatic int s_of(input int i);
        case (i)
            0: return 1;
            1: return 2;
            2: return 3;
            3: return 4;
            4: return 6;
            5: return 8;
            6: return 12;
            default: return 16;
        endcase
    endfunction

    md4_block_pipe #(.STEPS_PER_CYCLE(1), .BYTESWAP(1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(m_in_valid), .in_ready(m_in_ready),
        .state_a(st_a), .state_b(st_b), .state_c(st_c), .state_d(st_d), .data(data),
        .out_valid(m_out_valid), .out_ready(m_out_ready),
        .newstate_a(m_na), .newstate_b(m_nb), .newstate_c(m_nc), .newstate_d(m_nd),
        .busy(m_busy)
    );

    for (genvar gi = 0; gi < 16; gi++) begin : g_sw
        md4_block_pipe #(.STEPS_PER_CYCLE(s_of(gi / 2)), .BYTESWAP(gi % 2)) u_dut (
            .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(sw_in_ready[gi]),
            .state_a(st_a), .state_b(st_b), .state_c(st_c), .state_d(st_d), .data(data),
            .out_valid(sw_valid[gi]), .out_ready(s_out_ready),
            .newstate_a(sw_a[gi]), .newstate_b(sw_b[gi]), .newstate_c(sw_c[gi]), .newstate_d(sw_d[gi]),
            .busy(sw_busy[gi])
        );
    end

    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [127:0] md4_model(input logic [127:0] st, input logic [511:0] blk, input bit bs);
        logic [31:0] x [16];
        logic [31:0] a, b, c, d, w;
        int r3 [4] = '{0, 2, 1, 3};
        for (int i = 0; i < 16; i++) begin
            w = blk[511 - 32*i -: 32];
            x[i] = bs ? {w[7:0], w[15:8], w[23:16], w[31:24]} : w;
        end
        a = st[127:96]; b = st[95:64]; c = st[63:32]; d = st[31:0];
        for (int i = 0; i < 16; i += 4) begin
            a = rl(a + ((b & c) | (~b & d)) + x[i],   3);
            d = rl(d + ((a & b) | (~a & c)) + x[i+1], 7);
            c = rl(c + ((d & a) | (~d & b)) + x[i+2], 11);
            b = rl(b + ((c & d) | (~c & a)) + x[i+3], 19);
        end
        for (int j = 0; j < 4; j++) begin
            a = rl(a + ((b & c) | (b & d) | (c & d)) + x[j]    + 32'h5A827999, 3);
            d = rl(d + ((a & b) | (a & c) | (b & c)) + x[j+4]  + 32'h5A827999, 5);
            c = rl(c + ((d & a) | (d & b) | (a & b)) + x[j+8]  + 32'h5A827999, 9);
            b = rl(b + ((c & d) | (c & a) | (d & a)) + x[j+12] + 32'h5A827999, 13);
        end
        for (int j = 0; j < 4; j++) begin
            a = rl(a + (b ^ c ^ d) + x[r3[j]]      + 32'h6ED9EBA1, 3);
            d = rl(d + (a ^ b ^ c) + x[r3[j] + 8]  + 32'h6ED9EBA1, 9);
            c = rl(c + (d ^ a ^ b) + x[r3[j] + 4]  + 32'h6ED9EBA1, 11);
            b = rl(b + (c ^ d ^ a) + x[r3[j] + 12] + 32'h6ED9EBA1, 15);
        end
        return {st[127:96] + a, st[95:64] + b, st[63:32] + c, st[31:0] + d};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Counts edges until the main DUT shows out_valid; -1 on timeout.
    task automatic wait_main(output int lat);
        bit seen;
        lat  = -1;
        seen = 1'b0;
        for (int cyc = 1; cyc <= 100 && !seen; cyc++) begin
            @(posedge clk);
            #1;
            if (m_out_valid) begin
                lat  = cyc;
                seen = 1'b1;
            end
        end
    endtask

    task automatic set_block(input logic [127:0] st, input logic [511:0] blk);
        {st_a, st_b, st_c, st_d} = st;
        data = blk;
    endtask

    function automatic logic [511:0] rand_block();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    initial begin
        int lat;
        int slat [16];
        logic [127:0] held, exp_a, exp_b, st_r;
        logic [511:0] blk_a, blk_b;
        bit all_done;

        rst = 1'b1;
        m_in_valid = 1'b0; m_out_ready = 1'b0;
        s_in_valid = 1'b0; s_out_ready = 1'b0;
        set_block('0, '0);
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", 128'(m_out_valid), 128'(0));
        check("reset busy", 128'(m_busy), 128'(0));
        check("reset in_ready", 128'(m_in_ready), 128'(1));
        check("reset newstate", {m_na, m_nb, m_nc, m_nd}, 128'(0));
        rst = 1'b0;

        // Empty message, S=1, followed by back-pressure while DONE.
        set_block(IV, BLK_EMPTY);
        m_in_valid = 1'b1;
        @(posedge clk);
        #1;
        m_in_valid = 1'b0;
        check("run busy", 128'(m_busy), 128'(1));
        check("run in_ready", 128'(m_in_ready), 128'(0));
        wait_main(lat);
        check("empty latency", 128'(lat), 128'(49));
        check("empty digest", {m_na, m_nb, m_nc, m_nd}, EXP_EMPTY);
        held = {m_na, m_nb, m_nc, m_nd};
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp%0d out_valid", i), 128'(m_out_valid), 128'(1));
            check($sformatf("bp%0d stable", i), {m_na, m_nb, m_nc, m_nd}, held);
            check($sformatf("bp%0d in_ready", i), 128'(m_in_ready), 128'(0));
        end
        m_out_ready = 1'b1;
        #1;
        check("done in_ready follows out_ready", 128'(m_in_ready), 128'(1));
        @(posedge clk);
        #1;
        check("consume out_valid", 128'(m_out_valid), 128'(0));
        check("consume idle", 128'(m_in_ready), 128'(1));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("single completion %0d", i), 128'(m_out_valid), 128'(0));
        end

        // Back-to-back: second block accepted on the edge the first is consumed.
        st_r  = {$urandom, $urandom, $urandom, $urandom};
        blk_a = rand_block();
        blk_b = rand_block();
        exp_a = md4_model(st_r, blk_a, 1'b1);
        exp_b = md4_model(IV, blk_b, 1'b1);
        set_block(st_r, blk_a);
        m_in_valid = 1'b1;
        @(posedge clk);
        #1;
        set_block(IV, blk_b);
        wait_main(lat);
        check("b2b first latency", 128'(lat), 128'(49));
        check("b2b first digest", {m_na, m_nb, m_nc, m_nd}, exp_a);
        check("b2b in_ready in done", 128'(m_in_ready), 128'(1));
        @(posedge clk);
        #1;
        m_in_valid = 1'b0;
        check("b2b out_valid drop", 128'(m_out_valid), 128'(0));
        check("b2b second running", 128'(m_busy), 128'(1));
        wait_main(lat);
        check("b2b second latency", 128'(lat), 128'(49));
        check("b2b second digest", {m_na, m_nb, m_nc, m_nd}, exp_b);
        @(posedge clk);
        #1;
        check("b2b back to idle", 128'(m_in_ready), 128'(1));

        // Reset at step 20 discards the block in flight.
        set_block(IV, rand_block());
        m_in_valid = 1'b1;
        @(posedge clk);
        #1;
        m_in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid reset out_valid", 128'(m_out_valid), 128'(0));
        check("mid reset newstate", {m_na, m_nb, m_nc, m_nd}, 128'(0));
        check("mid reset in_ready", 128'(m_in_ready), 128'(1));
        check("mid reset busy", 128'(m_busy), 128'(0));
        set_block(IV, BLK_EMPTY);
        m_in_valid = 1'b1;
        @(posedge clk);
        #1;
        m_in_valid = 1'b0;
        wait_main(lat);
        check("post reset latency", 128'(lat), 128'(49));
        check("post reset digest", {m_na, m_nb, m_nc, m_nd}, EXP_EMPTY);

        // Parameter sweep: "abc" first, then random chaining values and blocks.
        for (int v = 0; v < 4; v++) begin
            if (v == 0) set_block(IV, BLK_ABC);
            else        set_block({$urandom, $urandom, $urandom, $urandom}, rand_block());
            s_in_valid = 1'b1;
            @(posedge clk);
            #1;
            s_in_valid = 1'b0;
            for (int i = 0; i < 16; i++) slat[i] = 0;
            all_done = 1'b0;
            for (int cyc = 1; cyc <= 60 && !all_done; cyc++) begin
                @(posedge clk);
                #1;
                all_done = 1'b1;
                for (int i = 0; i < 16; i++) begin
                    if (sw_valid[i] && slat[i] == 0) slat[i] = cyc;
                    if (slat[i] == 0) all_done = 1'b0;
                end
            end
            for (int i = 0; i < 16; i++) begin
                check($sformatf("sweep v%0d S%0d BS%0d latency", v, s_of(i / 2), i % 2),
                      128'(slat[i]), 128'(48 / s_of(i / 2) + 1));
                check($sformatf("sweep v%0d S%0d BS%0d digest", v, s_of(i / 2), i % 2),
                      {sw_a[i], sw_b[i], sw_c[i], sw_d[i]},
                      md4_model({st_a, st_b, st_c, st_d}, data, bit'(i % 2)));
                if (v == 0 && (i % 2) == 1)
                    check($sformatf("abc S%0d known digest", s_of(i / 2)),
                          {sw_a[i], sw_b[i], sw_c[i], sw_d[i]}, EXP_ABC);
            end
            s_out_ready = 1'b1;
            @(posedge clk);
            #1;
            s_out_ready = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
